// File: rtl/aes128_key_schedule.sv
// Iterative AES-128 key expansion into an 11-entry round-key register file served by index.
// Define AES_KS_SERIAL_SBOX_EN to share one S-box (one SubWord byte per cycle, 4 cycles/round).
module aes128_key_schedule #(
    parameter int unsigned NROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [3:0]   rk_idx,
    output logic [127:0] round_key,
    output logic         busy,
    output logic         finish
);

    localparam logic [3:0] LastIdx = 4'(NROUNDS);

    typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] rk_q [NROUNDS+1];
    logic         rk_we;
    logic [3:0]   rk_waddr;
    logic [127:0] rk_wdata;
    logic [127:0] prev_rk, next_rk;
    logic [31:0]  rot_w, sub_w, t_w, w0, w1, w2, w3;
    logic         step_en;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 (0 maps to 0), then the FIPS affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127, inv;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        inv  = gf_mul(x127, x127);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Word j of a round key sits at [32j+31:32j] with its first byte in the low bits.
    assign prev_rk = rk_q[round_q - 4'd1];
    assign rot_w   = {prev_rk[103:96], prev_rk[127:104]};
    assign t_w     = sub_w ^ {24'h0, rcon_q};
    assign w0      = prev_rk[31:0] ^ t_w;
    assign w1      = prev_rk[63:32] ^ w0;
    assign w2      = prev_rk[95:64] ^ w1;
    assign w3      = prev_rk[127:96] ^ w2;
    assign next_rk = {w3, w2, w1, w0};

`ifdef AES_KS_SERIAL_SBOX_EN
    logic [1:0]  byte_q, byte_d;
    logic [31:0] part_q, part_d;
    logic [7:0]  sb_out;

    assign sb_out  = sbox(rot_w[{byte_q, 3'b000} +: 8]);
    // part_q[31:24] is always zero, so the final byte is simply merged in.
    assign sub_w   = part_q | {sb_out, 24'h0};
    assign step_en = (byte_q == 2'd3);

    always_comb begin
        byte_d = 2'd0;
        part_d = '0;
        if (state_q == StExpand && start && !step_en) begin
            byte_d = byte_q + 2'd1;
            part_d = part_q;
            part_d[{byte_q, 3'b000} +: 8] = sb_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_q <= 2'd0;
            part_q <= '0;
        end else begin
            byte_q <= byte_d;
            part_q <= part_d;
        end
    end
`else
    assign sub_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]),
                      sbox(rot_w[7:0])};
    assign step_en = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        rcon_d   = rcon_q;
        rk_we    = 1'b0;
        rk_waddr = round_q;
        rk_wdata = next_rk;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StExpand;
                    round_d  = 4'd1;
                    rcon_d   = 8'h01;
                    rk_we    = 1'b1;
                    rk_waddr = 4'd0;
                    rk_wdata = key;
                end
            end
            StExpand: begin
                if (!start) begin
                    state_d = StIdle;
                end else if (step_en) begin
                    rk_we   = 1'b1;
                    rcon_d  = xtime(rcon_q);
                    round_d = round_q + 4'd1;
                    if (round_q == LastIdx) state_d = StDone;
                end
            end
            StDone: begin
                if (!start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
            for (int unsigned i = 0; i <= NROUNDS; i++) rk_q[i] <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            if (rk_we) rk_q[rk_waddr] <= rk_wdata;
        end
    end

    assign round_key = (rk_idx <= LastIdx) ? rk_q[rk_idx] : '0;
    assign busy      = (state_q == StExpand);
    assign finish    = (state_q == StDone);

endmodule

// File: tb/tb_aes128_key_schedule.sv
// Bench for aes128_key_schedule: byte-level FIPS-197 expansion model, per-cycle compare, directed tests.
// Honours AES_KS_SERIAL_SBOX_EN for the expected round latency.
module tb_aes128_key_schedule;

`ifdef AES_KS_SERIAL_SBOX_EN
    localparam int CPR = 4;
`else
    localparam int CPR = 1;
`endif
    localparam int LAT = 1 + 10 * CPR;

    localparam logic [127:0] K1     = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] K1_RK1 = 128'h05766c2a3939a323b12c548817fefaa0;
    localparam logic [127:0] K1_RK10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
    localparam logic [127:0] K0_RK1 = 128'h63636362636363626363636263636362;
    localparam logic [127:0] PT     = 128'h2a179373117e3de9969f402ee2bec16b;
    localparam logic [127:0] CT     = 128'h97ef6624f3ca9ea860367a0db47bd73a;

    typedef logic [10:0][127:0] ks_t;

    logic         clk, rst, start;
    logic [127:0] key, round_key;
    logic [3:0]   rk_idx;
    logic         busy, finish;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    logic [7:0] sb_tab [256];

    aes128_key_schedule #(.NROUNDS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .rk_idx(rk_idx),
        .round_key(round_key), .busy(busy), .finish(finish)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic ks_t expand_key(input logic [127:0] k);
        logic [7:0] w [44][4];
        logic [7:0] t [4];
        logic [7:0] rc, f;
        ks_t ks;
        rc = 8'h01;
        for (int j = 0; j < 4; j++) for (int b = 0; b < 4; b++) w[j][b] = k[8*(4*j+b) +: 8];
        for (int j = 4; j < 44; j++) begin
            for (int b = 0; b < 4; b++) t[b] = w[j-1][b];
            if (j % 4 == 0) begin
                f = t[0];
                t[0] = sb_tab[t[1]] ^ rc;
                t[1] = sb_tab[t[2]];
                t[2] = sb_tab[t[3]];
                t[3] = sb_tab[f];
                rc = gmul(rc, 8'h02);
            end
            for (int b = 0; b < 4; b++) w[j][b] = w[j-4][b] ^ t[b];
        end
        for (int r = 0; r < 11; r++)
            for (int j = 0; j < 4; j++)
                for (int b = 0; b < 4; b++) ks[r][32*j+8*b +: 8] = w[4*r+j][b];
        return ks;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input ks_t ks);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] ct;
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ ks[0][8*i +: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) s[rw+4*c] = t[rw+4*((c+rw)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[r][8*i +: 8];
        end
        for (int i = 0; i < 16; i++) ct[8*i +: 8] = s[i];
        return ct;
    endfunction

    // Protocol model: phase 0 idle, 1 expanding, 2 done; keys appear one per CPR cycles.
    int           m_phase, m_cnt, m_next;
    ks_t          m_full;
    logic [127:0] m_rk [11];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_next  <= 0;
            for (int i = 0; i < 11; i++) m_rk[i] <= '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_full  <= expand_key(key);
                    m_rk[0] <= key;
                    m_next  <= 1;
                    m_cnt   <= 0;
                    m_phase <= 1;
                end
                1: if (!start) begin
                    m_phase <= 0;
                end else if (m_cnt == CPR - 1) begin
                    m_rk[m_next] <= m_full[m_next];
                    m_cnt        <= 0;
                    m_next       <= m_next + 1;
                    if (m_next == 10) m_phase <= 2;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                default: if (!start) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", 128'(busy), 128'(m_phase == 1));
            check("cyc_finish", 128'(finish), 128'(m_phase == 2));
            check("cyc_round_key", round_key, (rk_idx <= 4'd10) ? m_rk[rk_idx] : 128'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        rk_idx = rk_idx + 4'd1;
    endtask

    task automatic run_to_finish(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!finish && n < 200);
        check(name, 128'(n), 128'(LAT));
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
        rk_idx = idx;
        #1;
        val = round_key;
    endtask

    logic [127:0] v;
    ks_t          ks_a, dut_ks;

    initial begin
        rst = 1; start = 0; key = '0; rk_idx = '0;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s, c;
            inv = 8'h00;
            c = 8'h63;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb_tab[x] = s;
        end
        #1 rst = 0;
        @(posedge clk);
        #2;
        check("reset_busy", 128'(busy), 128'h0);
        check("reset_finish", 128'(finish), 128'h0);
        read_rk(4'd0, v);  check("reset_rk0", v, 128'h0);
        read_rk(4'd10, v); check("reset_rk10", v, 128'h0);
        rst = 1;
        cmp_en = 1;

        check("model_sbox_00", 128'(sb_tab[8'h00]), 128'h63);
        check("model_sbox_53", 128'(sb_tab[8'h53]), 128'hed);
        ks_a = expand_key(K1);
        check("model_k1_rk1", ks_a[1], K1_RK1);
        check("model_k1_rk10", ks_a[10], K1_RK10);
        check("model_enc", aes_enc(PT, ks_a), CT);
        ks_a = expand_key(128'h0);
        check("model_k0_rk1", ks_a[1], K0_RK1);

        // Test 1: FIPS key, latency and round keys.
        tick();
        key = K1; start = 1;
        run_to_finish("t1_latency");
        read_rk(4'd0, v);  check("t1_rk0", v, K1);
        read_rk(4'd1, v);  check("t1_rk1", v, K1_RK1);
        read_rk(4'd10, v); check("t1_rk10", v, K1_RK10);

        // Test 6: chain the served round keys through an AES-128 encryption.
        for (int i = 0; i < 11; i++) begin
            read_rk(4'(i), v);
            dut_ks[i] = v;
        end
        check("t6_ciphertext", aes_enc(PT, dut_ks), CT);

        // Test 3: start held in DONE ignores a new key; drop and re-raise restarts.
        key = '1;
        repeat (5) tick();
        check("t3_finish_held", 128'(finish), 128'h1);
        read_rk(4'd1, v);  check("t3_rk1_kept", v, K1_RK1);
        read_rk(4'd10, v); check("t3_rk10_kept", v, K1_RK10);
        start = 0;
        tick();
        check("t3_finish_drop", 128'(finish), 128'h0);
        start = 1;
        run_to_finish("t3_relatency");
        read_rk(4'd0, v); check("t3_rk0_new", v, '1);

        // Test 2: all-zero key, out-of-range index.
        start = 0;
        tick();
        key = '0; start = 1;
        run_to_finish("t2_latency");
        read_rk(4'd1, v);  check("t2_rk1", v, K0_RK1);
        read_rk(4'd12, v); check("t2_idx12", v, 128'h0);
        read_rk(4'd15, v); check("t2_idx15", v, 128'h0);

        // Test 4: abort at round 5 leaves rk1..4 new, rk5..10 from the zero key.
        start = 0;
        tick();
        key = K1; start = 1;
        repeat (1 + 4 * CPR) tick();
        start = 0;
        tick();
        check("t4_busy_abort", 128'(busy), 128'h0);
        repeat (LAT + 2) tick();
        check("t4_no_finish", 128'(finish), 128'h0);
        read_rk(4'd1, v);  check("t4_rk1_partial", v, K1_RK1);
        read_rk(4'd5, v);  check("t4_rk5_old", v, ks_a[5]);
        read_rk(4'd10, v); check("t4_rk10_old", v, ks_a[10]);
        start = 1;
        run_to_finish("t4_restart_latency");
        read_rk(4'd10, v); check("t4_rk10", v, K1_RK10);

        // Test 5: asynchronous reset mid-expansion.
        start = 0;
        tick();
        start = 1;
        repeat (3) tick();
        #1 rst = 0;
        #1;
        check("t5_busy", 128'(busy), 128'h0);
        check("t5_finish", 128'(finish), 128'h0);
        for (int i = 0; i < 11; i++) begin
            read_rk(4'(i), v);
            check("t5_rk_zero", v, 128'h0);
        end
        start = 0;
        @(posedge clk);
        #2 rst = 1;
        repeat (3) tick();
        check("t5_idle_after", 128'(busy), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
